// File: rtl/prio_scan.sv
// prio_scan: takes a bitmap word and emits the index of each set bit, MSB first,
// one per out handshake. Define PRIO_SCAN_LAST_EN to add the out_last end-of-word marker.
module prio_scan #(
    parameter int unsigned WIDTH_LOG = 4,
    parameter int unsigned IDX_W     = 8,
    localparam int unsigned WIDTH    = 1 << WIDTH_LOG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
`ifdef PRIO_SCAN_LAST_EN
    output logic             out_last,
`endif
    output logic             zero_word,
    output logic             busy
);

    if (WIDTH_LOG < 1 || WIDTH_LOG > 7 || IDX_W < WIDTH_LOG) begin : g_bad_params
        $error("prio_scan: illegal WIDTH_LOG/IDX_W combination");
    end

    typedef enum logic [0:0] {StIdle, StEmit} st_e;

    st_e              st_q, st_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             zero_word_q, zero_word_d;

    logic [WIDTH-1:0]     win;
    logic [WIDTH_LOG-1:0] msb_pos;
    logic [WIDTH-1:0]     clr;
    logic [WIDTH-1:0]     mask_clr;

    // Halving search: at each level keep whichever half holds the highest set bit.
    always_comb begin
        win     = mask_q;
        msb_pos = '0;
        for (int l = int'(WIDTH_LOG) - 1; l >= 0; l--) begin
            if ((win >> (1 << l)) != '0) begin
                msb_pos = msb_pos | (WIDTH_LOG'(1) << l);
                win     = win >> (1 << l);
            end
        end
    end

    assign clr      = WIDTH'(1) << msb_pos;
    assign mask_clr = mask_q & ~clr;

    always_comb begin
        st_d        = st_q;
        mask_d      = mask_q;
        zero_word_d = 1'b0;
        if (flush) begin
            st_d   = StIdle;
            mask_d = '0;
        end else begin
            unique case (st_q)
                StIdle: begin
                    if (in_valid) begin
                        if (in_data != '0) begin
                            mask_d = in_data;
                            st_d   = StEmit;
                        end else begin
                            zero_word_d = 1'b1;
                        end
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        mask_d = mask_clr;
                        if (mask_clr == '0) begin
                            st_d = StIdle;
                        end
                    end
                end
                default: begin
                    st_d   = StIdle;
                    mask_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= StIdle;
            mask_q      <= '0;
            zero_word_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            mask_q      <= mask_d;
            zero_word_q <= zero_word_d;
        end
    end

    assign in_ready  = (st_q == StIdle) && !flush;
    assign out_valid = (st_q == StEmit);
    assign busy      = (st_q == StEmit);
    assign out_idx   = IDX_W'(msb_pos);
    assign zero_word = zero_word_q;

`ifdef PRIO_SCAN_LAST_EN
    // Exactly one bit left means this index closes the word.
    assign out_last = out_valid && ((mask_q & (mask_q - WIDTH'(1))) == '0);
`endif

endmodule

// File: tb/tb_prio_scan.sv
// Self-checking bench for prio_scan: queue-based scoreboard fed by a set-bit list model.
// Directed cases from the block's test plan, then randomized words, ready and flush.
module tb_prio_scan;

    localparam int unsigned WL = 5;
    localparam int unsigned W  = 1 << WL;
    localparam int unsigned IW = 8;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data   = '0;
    logic          in_ready;
    logic          out_valid;
    logic          zero_word;
    logic          busy;
    logic [IW-1:0] out_idx;
`ifdef PRIO_SCAN_LAST_EN
    logic          out_last;
`endif

    int checks    = 0;
    int failures  = 0;
    int tmo_count = 0;
    int tmo_seen  = 0;
    int delivered = 0;
    bit rr_mode   = 1'b0;
    bit zero_exp  = 1'b0;
    int q[$];

    prio_scan #(
        .WIDTH_LOG(WL),
        .IDX_W    (IW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
`ifdef PRIO_SCAN_LAST_EN
        .out_last (out_last),
`endif
        .zero_word(zero_word),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor and reference model; expected indices per word are simply its set bits, high to low.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_zero_word", zero_word, 0);
            check("rst_out_idx", out_idx, 0);
            check("rst_in_ready", in_ready, !flush);
`ifdef PRIO_SCAN_LAST_EN
            check("rst_out_last", out_last, 0);
`endif
            q.delete();
            zero_exp = 1'b0;
        end else begin
            bit exp_valid;
            exp_valid = (q.size() != 0);
            if (tmo_count != tmo_seen) begin
                checks++;
                failures++;
                $display("FAIL timeout: got %0d expired waits, expected 0", tmo_count - tmo_seen);
                tmo_seen = tmo_count;
            end
            check("out_valid", out_valid, exp_valid);
            check("busy", busy, exp_valid);
            check("in_ready", in_ready, !exp_valid && !flush);
            check("zero_word", zero_word, zero_exp);
            check("out_idx", out_idx, exp_valid ? q[0] : 0);
`ifdef PRIO_SCAN_LAST_EN
            check("out_last", out_last, exp_valid && q.size() == 1);
`endif
            zero_exp = 1'b0;
            if (exp_valid && out_ready) begin
                void'(q.pop_front());
                delivered++;
            end
            if (flush) begin
                q.delete();
            end else if (!exp_valid && in_valid) begin
                if (in_data == '0) begin
                    zero_exp = 1'b1;
                end else begin
                    for (int i = W - 1; i >= 0; i--) begin
                        if (in_data[i]) q.push_back(i);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rr_mode) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
        end
    endtask

    task automatic send(input logic [W-1:0] w);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) tmo_count++;
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && q.size() != 0; n++) tick();
        if (q.size() != 0) tmo_count++;
        tick();
    endtask

    initial begin
        logic [W-1:0] w;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        send(32'h0000_8421);
        drain();

        send('0);
        send('0);
        send('0);
        tick();
        tick();

        out_ready = 1'b0;
        send(32'h0000_0003);
        repeat (5) tick();
        out_ready = 1'b1;
        drain();

        // Flush while idx 14 is presented and not taken.
        send(32'h0000_F000);
        tick();
        out_ready = 1'b0;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        out_ready = 1'b0;
        send(32'h0000_FFFF);
        tick();
        tick();
        @(posedge clk);
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(32'h0000_0001);
        drain();

        send(32'hFFFF_FFFF);
        drain();

        rr_mode = 1'b1;
        repeat (200) begin
            case ($urandom_range(0, 5))
                0:       w = '0;
                1:       w = '1;
                2:       w = W'(1) << $urandom_range(0, W - 1);
                default: w = W'($urandom);
            endcase
            send(w);
            if ($urandom_range(0, 2) == 0) drain();
        end
        rr_mode   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drain();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
